// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice.
//   - Default geometry (depth, address and data widths).
//   - Pointer-width helper so every file derives ring-index widths the same way.
//   - Entry layout {addr, data} at the default widths.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // Ring index width; depth is a power of two >= 2, so this is log2(depth).
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int SB_PTR_W = ptr_w(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the CPU store/load path and the data-memory port seen by the
// store buffer.
//   CPU store : st_valid, st_addr, st_data  -> buffer;  st_ready <- buffer
//   CPU load  : ld_valid, ld_addr           -> buffer;  ld_data, ld_hit, ld_stall <- buffer
//   Memory    : mem_we, mem_a, mem_wd       <- buffer;  mem_rd -> buffer
//   Status    : count, empty                <- buffer
// Modport slave is the buffer; modport master is the CPU/memory side.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) ();

  localparam int CNT_W = ptr_w(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_hit;
  logic              ld_stall;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  logic [CNT_W-1:0]  count;
  logic              empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    output st_ready, ld_data, ld_hit, ld_stall, mem_we, mem_a, mem_wd, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    input  st_ready, ld_data, ld_hit, ld_stall, mem_we, mem_a, mem_wd, count, empty
  );

endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-match search for store-to-load forwarding.
//   ent_addr/ent_data : buffer contents indexed by ring slot
//   ent_vld           : occupied-slot mask
//   rd_ptr            : slot of the oldest entry
//   ld_addr           : load address to match
//   hit/data          : some occupied entry matches / data of the youngest match
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] ent_addr [DEPTH],
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  input  logic [DEPTH-1:0]  ent_vld,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the surviving data belongs to the youngest matching store.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (ent_vld[idx] && (ent_addr[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the CPU load/store path and word-addressed data memory.
// Stores are queued in a circular FIFO and drained one per cycle whenever the
// memory port is not needed by a load; loads that match a buffered store are
// answered from the youngest matching entry.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; discards all pending stores
//   sb    : store_buffer_if.slave (CPU store/load, memory port, count/empty)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  store_buffer_if.slave   sb
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            entry_q [DEPTH];
  entry_t            entry_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              enq;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_hit;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  age;

  // Slot i is occupied when its distance from the oldest entry is below count.
  always_comb begin
    ent_vld = '0;
    age     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = entry_q[i].addr;
      ent_data[i] = entry_q[i].data;
      age         = PTR_W'(i) - rd_ptr_q;
      ent_vld[i]  = ({1'b0, age} < count_q);
    end
  end

  store_buffer_fwd #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .rd_ptr   (rd_ptr_q),
    .ld_addr  (sb.ld_addr),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

  assign full   = (count_q == FULL_CNT);
  assign enq    = sb.st_valid && !full;
  assign ld_hit = sb.ld_valid && fwd_hit;

  // A missing load owns the memory port unless the buffer is full, in which
  // case the oldest store is forced out and the load stalls for that cycle.
  assign drain = (count_q != '0) && (!sb.ld_valid || ld_hit || full);

  assign sb.st_ready = !full;
  assign sb.ld_hit   = ld_hit;
  assign sb.ld_data  = ld_hit ? fwd_data : sb.mem_rd;
  assign sb.ld_stall = sb.ld_valid && !ld_hit && drain;
  assign sb.mem_we   = drain;
  assign sb.mem_a    = drain ? entry_q[rd_ptr_q].addr : sb.ld_addr;
  assign sb.mem_wd   = entry_q[rd_ptr_q].data;
  assign sb.count    = count_q;
  assign sb.empty    = (count_q == '0);

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      entry_d[wr_ptr_q] = '{addr: sb.st_addr, data: sb.st_data};
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the single-cycle datapath's load/store path and the word-addressed data memory.
- Accepts stores from the CPU and queues them in a small FIFO.
- Drains one store per cycle into data memory whenever the memory port is free.
- Forwards the youngest buffered store data to matching loads, so loads never see stale memory.

Parameters:
DEPTH, 4, number of buffer entries; power of two, >= 2
ADDR_W, 32, store/load address width; word address, driven straight to memory A
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
st_valid  in  1  CPU store request
st_addr  in  ADDR_W  store word address
st_data  in  DATA_W  store data
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  CPU load request
ld_addr  in  ADDR_W  load word address
ld_data  out  DATA_W  load result (forwarded or memory)
ld_hit  out  1  load satisfied from buffer
ld_stall  out  1  load cannot complete this cycle; CPU must hold
mem_we  out  1  data memory write enable
mem_a  out  ADDR_W  data memory address
mem_wd  out  DATA_W  data memory write data
mem_rd  in  DATA_W  data memory combinational read data
count  out  clog2(DEPTH)+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Storage: circular FIFO of {addr, data}, rd_ptr/wr_ptr of log2(DEPTH) bits with natural wrap, plus count.
- Reset (async, active-high): pointers, count and all entries = 0. Outputs: st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_stall=0. Pending stores are discarded; reset mid-drain aborts with no further writes.
- st_ready = (count != DEPTH), combinational from registered count. Enqueue = st_valid && st_ready, written at wr_ptr on the next edge.
- A store offered while full is not taken. The CPU holds st_valid/addr/data until accepted.
- Forwarding (combinational):
  - Compare ld_addr (full ADDR_W) against all occupied entries; youngest matching entry wins.
  - ld_hit = ld_valid && match.
  - ld_data = hit ? youngest match data : mem_rd.
  - A store being enqueued in the same cycle is NOT forwarded; it becomes visible the next cycle.
- Drain condition: drain = (count != 0) && (!ld_valid || ld_hit || count == DEPTH).
  - Loads get port priority unless the buffer is full.
  - A hit load does not need the port.
- Memory port:
  - mem_we = drain.
  - mem_a = drain ? entry[rd_ptr].addr : ld_addr.
  - mem_wd = entry[rd_ptr].data.
  - On a drain, rd_ptr advances on the next edge.
- ld_stall = ld_valid && !ld_hit && drain. This can only occur when full; it lasts exactly one cycle per forced drain.
- Count update:
  - Enqueue and drain in the same cycle: count unchanged, both pointers advance.
  - Enqueue only: +1. Drain only: -1.
  - Count never exceeds DEPTH and never underflows.
- Ordering: memory writes occur strictly in enqueue order, so same-address stores land in program order.
- Latency: store to memory write is at least 1 cycle after acceptance. A store is visible to loads 1 cycle after acceptance.

Decomposition:
- Shared package: DEPTH/ADDR_W/DATA_W defaults, pointer-width constant (log2 DEPTH), entry struct {addr, data}.
- Sub-module store_buffer_fwd: combinational youngest-match search.
  - Inputs: entries, valid mask, rd_ptr, ld_addr.
  - Outputs: hit, data.
- The top level holds the FIFO, pointers, count and port mux.

Test Plan:
- Reset with prior traffic -> count=0, empty=1, st_ready=1, mem_we=0, ld_stall=0.
- Store addr=5, data=0xDEADBEEF, ld_valid=0 -> next cycle count=1, mem_we=1, mem_a=5, mem_wd=0xDEADBEEF; the cycle after that count=0, empty=1.
- ld_valid=1, ld_addr=9 held (miss, mem_rd=0x00000009); enqueue stores to addr 1..4 -> no drains until count=4.
  - Then st_ready=0, ld_stall=1, mem_we=1, mem_a=1, ld_data=mem_rd.
  - Next cycle count=3, ld_stall=0.
- Load held at addr 3 (miss); enqueue addr 7/0x11, then addr 7/0x22; switch ld_addr=7 -> ld_hit=1, ld_data=0x22, ld_stall=0. Drain of the 0x11 entry is permitted that cycle.
- count=2, ld_valid=0, st_valid=1 (addr 8/0x33) -> count stays 2. Subsequent mem writes appear in enqueue order, with addr 8 last.
- count=3, reset asserted between edges -> count=0, mem_we=0 immediately. After release, no writes of the discarded entries ever appear.
